// File: rtl/alu32_pkg.sv
// Shared types and opcode constants for the two-requester ALU32 sequencer.
package alu32_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned SHAMT_W = 5;
   localparam int unsigned OP_W    = 4;

   localparam logic [OP_W-1:0] OP_ADD = 4'b1100;
   localparam logic [OP_W-1:0] OP_SUB = 4'b1110;
   localparam logic [OP_W-1:0] OP_AND = 4'b0100;
   localparam logic [OP_W-1:0] OP_OR  = 4'b0110;
   localparam logic [OP_W-1:0] OP_NOR = 4'b1000;
   localparam logic [OP_W-1:0] OP_XOR = 4'b1010;
   localparam logic [OP_W-1:0] OP_SLL = 4'b0010;
   localparam logic [OP_W-1:0] OP_SRL = 4'b0000;
   localparam logic [OP_W-1:0] OP_SRA = 4'b0001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // One ALU operation as presented to the ALU32 input ports.
   typedef struct packed {
      logic [OP_W-1:0]    opcode;
      logic [DATA_W-1:0]  in1;
      logic [DATA_W-1:0]  in2;
      logic [SHAMT_W-1:0] shamt;
   } alu_op_t;

   function automatic logic is_legal_op(input logic [OP_W-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR,
         OP_XOR, OP_SLL, OP_SRL, OP_SRA: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; the pointer moves to the loser after every grant.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] grant
);

   logic ptr;

   always_comb begin
      grant = 2'b00;
      if (en) begin
         case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= 1'b0;
      end else if (|grant) begin
         ptr <= grant[0];
      end
   end

endmodule

// File: rtl/alu32_arbiter.sv
// Shares one combinational ALU32 between two requesters (IDLE -> EXEC -> RESP).
// Optional illegal-opcode check enabled by defining ALU_ARB_OPCHECK_EN.
module alu32_arbiter
   import alu32_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [1:0]             reqValid,
   output logic [1:0]             reqReady,
   input  logic [2*OP_W-1:0]      reqOpCode,
   input  logic [2*DATA_W-1:0]    reqIn1,
   input  logic [2*DATA_W-1:0]    reqIn2,
   input  logic [2*SHAMT_W-1:0]   reqShAmt,
   output logic [1:0]             rspValid,
   input  logic [1:0]             rspReady,
   output logic [DATA_W-1:0]      rspData,
   output logic                   rspErr,
   output logic [OP_W-1:0]        aluOpCode,
   output logic [DATA_W-1:0]      aluIn1,
   output logic [DATA_W-1:0]      aluIn2,
   output logic [SHAMT_W-1:0]     aluShAmt,
   input  logic [DATA_W-1:0]      aluOut
);

   state_t     state;
   logic       owner;
   logic [1:0] grant;
   logic       arb_en;
   alu_op_t    win;
   alu_op_t    alu_q;

   // Grants are only offered in IDLE and never while reset is held.
   assign arb_en = rst_n && (state == IDLE);

   rr_arbiter2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (arb_en),
      .req   (reqValid),
      .grant (grant)
   );

   assign reqReady = grant;

   always_comb begin
      win.opcode = grant[1] ? reqOpCode[2*OP_W-1:OP_W]       : reqOpCode[OP_W-1:0];
      win.in1    = grant[1] ? reqIn1[2*DATA_W-1:DATA_W]      : reqIn1[DATA_W-1:0];
      win.in2    = grant[1] ? reqIn2[2*DATA_W-1:DATA_W]      : reqIn2[DATA_W-1:0];
      win.shamt  = grant[1] ? reqShAmt[2*SHAMT_W-1:SHAMT_W]  : reqShAmt[SHAMT_W-1:0];
   end

   assign aluOpCode = alu_q.opcode;
   assign aluIn1    = alu_q.in1;
   assign aluIn2    = alu_q.in2;
   assign aluShAmt  = alu_q.shamt;

`ifdef ALU_ARB_OPCHECK_EN
   logic err_q;
   assign rspErr = err_q;
`else
   assign rspErr = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         owner    <= 1'b0;
         rspValid <= 2'b00;
         rspData  <= '0;
         alu_q    <= '0;
`ifdef ALU_ARB_OPCHECK_EN
         err_q    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (|grant) begin
                  owner <= grant[1];
`ifdef ALU_ARB_OPCHECK_EN
                  // Illegal opcodes bypass the ALU and answer straight away.
                  if (!is_legal_op(win.opcode)) begin
                     rspData  <= '0;
                     err_q    <= 1'b1;
                     rspValid <= grant;
                     state    <= RESP;
                  end else begin
                     alu_q    <= win;
                     err_q    <= 1'b0;
                     state    <= EXEC;
                  end
`else
                  alu_q <= win;
                  state <= EXEC;
`endif
               end
            end
            EXEC: begin
               rspData  <= aluOut;
               rspValid <= owner ? 2'b10 : 2'b01;
               state    <= RESP;
            end
            RESP: begin
               if (rspReady[owner]) begin
                  rspValid <= 2'b00;
`ifdef ALU_ARB_OPCHECK_EN
                  err_q    <= 1'b0;
`endif
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu32_arbiter.sv
// Scoreboard bench for alu32_arbiter with a behavioural ALU32 on the ALU port.
module tb_alu32_arbiter;
   import alu32_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [1:0]           reqValid;
   logic [1:0]           reqReady;
   logic [2*OP_W-1:0]    reqOpCode;
   logic [2*DATA_W-1:0]  reqIn1;
   logic [2*DATA_W-1:0]  reqIn2;
   logic [2*SHAMT_W-1:0] reqShAmt;
   logic [1:0]           rspValid;
   logic [1:0]           rspReady;
   logic [DATA_W-1:0]    rspData;
   logic                 rspErr;
   logic [OP_W-1:0]      aluOpCode;
   logic [DATA_W-1:0]    aluIn1;
   logic [DATA_W-1:0]    aluIn2;
   logic [SHAMT_W-1:0]   aluShAmt;
   logic [DATA_W-1:0]    aluOut;

   logic [OP_W-1:0]    t_op [2];
   logic [DATA_W-1:0]  t_a  [2];
   logic [DATA_W-1:0]  t_b  [2];
   logic [SHAMT_W-1:0] t_sh [2];

   int errors = 0;
   int checks = 0;
   logic ptr = 1'b0;

   logic [DATA_W-1:0] sb_data  [$];
   logic [1:0]        sb_owner [$];

   assign reqOpCode = {t_op[1], t_op[0]};
   assign reqIn1    = {t_a[1],  t_a[0]};
   assign reqIn2    = {t_b[1],  t_b[0]};
   assign reqShAmt  = {t_sh[1], t_sh[0]};

   always #5 clk = ~clk;

   alu32_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .reqValid  (reqValid),
      .reqReady  (reqReady),
      .reqOpCode (reqOpCode),
      .reqIn1    (reqIn1),
      .reqIn2    (reqIn2),
      .reqShAmt  (reqShAmt),
      .rspValid  (rspValid),
      .rspReady  (rspReady),
      .rspData   (rspData),
      .rspErr    (rspErr),
      .aluOpCode (aluOpCode),
      .aluIn1    (aluIn1),
      .aluIn2    (aluIn2),
      .aluShAmt  (aluShAmt),
      .aluOut    (aluOut)
   );

   function automatic logic [DATA_W-1:0] alu_model(input logic [3:0] op, input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b, input logic [SHAMT_W-1:0] sh);
      case (op)
         4'b1100: return a + b;
         4'b1110: return a - b;
         4'b0100: return a & b;
         4'b0110: return a | b;
         4'b1000: return ~(a | b);
         4'b1010: return a ^ b;
         4'b0010: return a << sh;
         4'b0000: return a >> sh;
         4'b0001: return DATA_W'($signed(a) >>> sh);
         default: return '0;
      endcase
   endfunction

   // Stand-in for the ALU32 instance.
   always_comb aluOut = alu_model(aluOpCode, aluIn1, aluIn2, aluShAmt);

   function automatic logic [1:0] exp_grant(input logic [1:0] v, input logic p);
      case (v)
         2'b01:   return 2'b01;
         2'b10:   return 2'b10;
         2'b11:   return p ? 2'b10 : 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [3:0] op, input logic [DATA_W-1:0] a,
                          input logic [DATA_W-1:0] b, input logic [SHAMT_W-1:0] sh);
      t_op[i] = op; t_a[i] = a; t_b[i] = b; t_sh[i] = sh;
   endtask

   // Record the expected result of requester i and advance the model pointer.
   task automatic push(input int i);
      sb_data.push_back(alu_model(t_op[i], t_a[i], t_b[i], t_sh[i]));
      sb_owner.push_back(i == 1 ? 2'b10 : 2'b01);
      ptr = (i == 0);
   endtask

   task automatic pop(output logic [DATA_W-1:0] d, output logic [1:0] o);
      if (sb_data.size() > 0) begin
         d = sb_data.pop_front();
         o = sb_owner.pop_front();
      end else begin
         d = 'x;
         o = 2'bxx;
      end
   endtask

   // Wait (bounded) for a response, capture it, then complete the handshake.
   task automatic collect(output logic [1:0] v, output logic [DATA_W-1:0] d,
                          output logic e, output int lat);
      lat = 0;
      while (rspValid == 2'b00 && lat < 20) begin
         tick();
         lat++;
      end
      v = rspValid; d = rspData; e = rspErr;
      if (v != 2'b00) begin
         rspReady = v;
         tick();
         rspReady = 2'b00;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; reqValid = 2'b00; rspReady = 2'b00;
      tick(); tick();
      rst_n = 1'b1;
      ptr   = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; reqValid = 2'b11; rspReady = 2'b00;
      set_req(0, OP_ADD, 32'd1, 32'd2, 5'd0);
      set_req(1, OP_ADD, 32'd3, 32'd4, 5'd0);
      tick(); tick();
      checks++;
      if (reqReady !== 2'b00) begin errors++; $display("FAIL reset_reqReady got=%b exp=00", reqReady); end
      checks++;
      if (rspValid !== 2'b00 || rspData !== '0 || rspErr !== 1'b0) begin
         errors++; $display("FAIL reset_rsp got v=%b d=%h e=%b exp 00/0/0", rspValid, rspData, rspErr);
      end
      checks++;
      if (aluOpCode !== '0 || aluIn1 !== '0 || aluIn2 !== '0 || aluShAmt !== '0) begin
         errors++; $display("FAIL reset_alu got op=%h a=%h b=%h sh=%h exp 0", aluOpCode, aluIn1, aluIn2, aluShAmt);
      end
      reqValid = 2'b00;
      rst_n = 1'b1;
      ptr = 1'b0;
      tick();
   endtask

   task automatic test_single_add();
      logic [1:0] v, eo; logic [DATA_W-1:0] d, ed; logic e; int lat;
      set_req(0, OP_ADD, 32'd110, 32'd10, 5'd0);
      reqValid = 2'b01;
      #1;
      checks++;
      if (reqReady !== 2'b01) begin errors++; $display("FAIL add_grant got=%b exp=01", reqReady); end
      push(0);
      tick();
      reqValid = 2'b00;
      checks++;
      if (rspValid !== 2'b00 || reqReady[1] !== 1'b0 || aluOpCode !== OP_ADD || aluIn1 !== 32'd110 || aluIn2 !== 32'd10) begin
         errors++; $display("FAIL add_exec got v=%b rr1=%b op=%h a=%0d b=%0d exp 00/0/c/110/10",
                            rspValid, reqReady[1], aluOpCode, aluIn1, aluIn2);
      end
      collect(v, d, e, lat);
      pop(ed, eo);
      checks++;
      if (v !== eo || d !== ed || d !== 32'd120 || lat != 1) begin
         errors++; $display("FAIL add_rsp got v=%b d=%0d lat=%0d exp v=%b d=%0d lat=1", v, d, lat, eo, ed);
      end
      checks++;
      if (rspValid !== 2'b00) begin errors++; $display("FAIL add_release got rspValid=%b exp=00", rspValid); end
   endtask

   task automatic test_both_valid();
      logic [1:0] v, eo, g; logic [DATA_W-1:0] d, ed; logic e; int lat;
      do_reset();
      set_req(0, OP_SUB, 32'd110, 32'd10, 5'd0);
      set_req(1, OP_XOR, 32'd110, 32'd10, 5'd0);
      reqValid = 2'b11;
      // Both stay valid for four accepts: grants must alternate 01,10,01,10.
      for (int k = 0; k < 4; k++) begin
         #1;
         g = exp_grant(reqValid, ptr);
         checks++;
         if (reqReady !== g) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", k, reqReady, g); end
         push(g[1] ? 1 : 0);
         tick();
         if (k >= 1) begin
            set_req(0, OP_AND, 32'hFF00_FF00 ^ 32'(k), 32'h0F0F_0F0F, 5'd0);
            set_req(1, OP_NOR, 32'h1234_5678, 32'(k), 5'd0);
         end
         collect(v, d, e, lat);
         pop(ed, eo);
         checks++;
         if (v !== eo || d !== ed || (k < 2 && d !== 32'd100)) begin
            errors++; $display("FAIL rr_rsp%0d got v=%b d=%h exp v=%b d=%h", k, v, d, eo, ed);
         end
      end
      reqValid = 2'b00;
   endtask

   task automatic test_shift();
      logic [1:0] v, eo; logic [DATA_W-1:0] d, ed; logic e; int lat;
      logic [DATA_W-1:0] konst [2];
      konst[0] = 32'hE000_0003;
      konst[1] = 32'b111000;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) set_req(1, OP_SRA, 32'h8000_000C, 32'd0, 5'd2);
         else        set_req(1, OP_SLL, 32'b001110, 32'd0, 5'd2);
         reqValid = 2'b10;
         #1;
         checks++;
         if (reqReady !== 2'b10) begin errors++; $display("FAIL shift_grant%0d got=%b exp=10", k, reqReady); end
         push(1);
         tick();
         reqValid = 2'b00;
         collect(v, d, e, lat);
         pop(ed, eo);
         checks++;
         if (v !== eo || d !== ed || d !== konst[k]) begin
            errors++; $display("FAIL shift_rsp%0d got v=%b d=%h exp v=%b d=%h", k, v, d, eo, konst[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [1:0] eo, g; logic [DATA_W-1:0] ed, held;
      int bad;
      set_req(0, OP_OR, 32'hF0F0_0000, 32'h0000_0F0F, 5'd0);
      reqValid = 2'b01;
      #1;
      checks++;
      if (reqReady !== 2'b01) begin errors++; $display("FAIL bp_grant got=%b exp=01", reqReady); end
      push(0);
      tick();
      reqValid = 2'b11;
      #1;
      checks++;
      if (reqReady !== 2'b00) begin errors++; $display("FAIL bp_exec_ready got=%b exp=00", reqReady); end
      tick();
      pop(ed, eo);
      held = rspData;
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         if (rspValid !== eo || rspData !== ed || reqReady !== 2'b00) bad++;
         tick();
      end
      checks++;
      if (bad != 0 || held !== 32'hF0F0_0F0F) begin
         errors++; $display("FAIL bp_hold got bad_cycles=%0d d=%h exp 0 / f0f00f0f", bad, held);
      end
      rspReady = 2'b10;
      tick();
      checks++;
      if (rspValid !== eo) begin errors++; $display("FAIL bp_nonowner got rspValid=%b exp=%b", rspValid, eo); end
      rspReady = 2'b01;
      tick();
      rspReady = 2'b00;
      g = exp_grant(2'b11, ptr);
      checks++;
      if (rspValid !== 2'b00 || reqReady !== g) begin
         errors++; $display("FAIL bp_release got v=%b rr=%b exp v=00 rr=%b", rspValid, reqReady, g);
      end
      reqValid = 2'b00;
      tick();
   endtask

   task automatic test_opcheck();
      logic [1:0] v, eo; logic [DATA_W-1:0] d, ed, a_before; logic e; int lat;
      a_before = aluIn1;
      set_req(0, 4'b0011, 32'hDEAD_BEEF, 32'd5, 5'd1);
      reqValid = 2'b01;
      #1;
      push(0);
      tick();
      reqValid = 2'b00;
      collect(v, d, e, lat);
      pop(ed, eo);
`ifdef ALU_ARB_OPCHECK_EN
      checks++;
      if (v !== eo || d !== '0 || e !== 1'b1 || lat != 0 || aluIn1 !== a_before) begin
         errors++; $display("FAIL opcheck got v=%b d=%h err=%b lat=%0d a=%h exp v=%b d=0 err=1 lat=0 a=%h",
                            v, d, e, lat, aluIn1, eo, a_before);
      end
`else
      checks++;
      if (v !== eo || d !== ed || e !== 1'b0 || lat != 1 || aluIn1 !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL opcheck got v=%b d=%h err=%b lat=%0d a=%h exp v=%b d=%h err=0 lat=1 a=deadbeef",
                            v, d, e, lat, aluIn1, eo, ed);
      end
`endif
   endtask

   task automatic test_reset_mid();
      int seen;
      set_req(1, OP_ADD, 32'd7, 32'd9, 5'd3);
      reqValid = 2'b10;
      #1;
      checks++;
      if (reqReady !== 2'b10) begin errors++; $display("FAIL rmid_grant got=%b exp=10", reqReady); end
      tick();
      reqValid = 2'b00;
      rst_n = 1'b0;
      tick();
      checks++;
      if (rspValid !== 2'b00 || rspData !== '0 || aluOpCode !== '0 || aluIn1 !== '0 || aluIn2 !== '0 || aluShAmt !== '0) begin
         errors++; $display("FAIL rmid_outputs got v=%b d=%h op=%h a=%h b=%h sh=%h exp all 0",
                            rspValid, rspData, aluOpCode, aluIn1, aluIn2, aluShAmt);
      end
      rst_n = 1'b1;
      ptr = 1'b0;
      reqValid = 2'b11;
      #1;
      checks++;
      if (reqReady !== 2'b01) begin errors++; $display("FAIL rmid_idle_ptr got=%b exp=01", reqReady); end
      reqValid = 2'b00;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (rspValid !== 2'b00) seen++;
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL rmid_no_rsp got cycles_with_rsp=%0d exp=0", seen); end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) set_req(i, OP_ADD, '0, '0, '0);
      test_reset();
      test_single_add();
      test_both_valid();
      test_shift();
      test_backpressure();
      test_opcheck();
      test_reset_mid();
      checks++;
      if (sb_data.size() != 0) begin errors++; $display("FAIL scoreboard_drain got=%0d exp=0", sb_data.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200us;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu32_arbiter.md
# alu32_arbiter

Sequencing controller that shares one combinational ALU32 between two requesters. Accepts operations over per-requester valid/ready handshakes, arbitrates round-robin, drives the ALU's opCode/in1/in2/shAmt from registers, captures the result, and returns it to the owning requester with back-pressure. Sits between the two datapath clients (e.g. execute and address-calc paths) and the single ALU32 instance.

## Interface
- DATA_W, 32, operand/result width
- SHAMT_W, 5, shift-amount width
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- reqValid  in  2  request valid, bit i = requester i
- reqReady  out  2  request accepted this cycle (one-hot or zero)
- reqOpCode  in  8  {op1, op0}, 4 bits each, ALU32 encoding
- reqIn1 / reqIn2  in  2*DATA_W each  {req1, req0} operands
- reqShAmt  in  2*SHAMT_W  {req1, req0} shift amounts
- rspValid  out  2  response valid, bit = owning requester
- rspReady  in  2  response consumed
- rspData  out  DATA_W  result, shared bus, qualified by rspValid
- rspErr  out  1  illegal-opcode flag (only with the configuration macro enabled)
- aluOpCode  out  4  to ALU32 opCode
- aluIn1 / aluIn2  out  DATA_W  to ALU32 in1/in2
- aluShAmt  out  SHAMT_W  to ALU32 shAmt
- aluOut  in  DATA_W  from ALU32 out

## Operation
- FSM states: IDLE, EXEC, RESP. Reset → IDLE.
- IDLE: reqReady = grant of the round-robin arbiter over reqValid.
  - On handshake, latch the winner's opCode/in1/in2/shAmt into the ALU-driving registers.
  - Latch owner id.
  - Toggle the priority pointer to the other requester.
  - Go to EXEC.
- EXEC: capture aluOut into the result register; go to RESP. reqReady = 0.
- RESP: rspValid[owner] = 1, rspData = result. Hold data stable until rspReady[owner]; on that edge go to IDLE. rspReady of the non-owner is ignored.
- Arbitration:
  - Pointer resets to requester 0.
  - Only one valid: that requester wins regardless of pointer.
  - Both valid: pointer wins.
- Opcodes are passed through unmodified; the ALU defines semantics:
  - add 1100, sub 1110, and 0100, or 0110, nor 1000, xor 1010
  - sll 0010, srl 0000, sra 0001
- Arithmetic wraps modulo 2^DATA_W; no overflow flag.
- reqValid deasserted by a requester before its handshake: no state change.
- Reset mid-operation: FSM → IDLE, pointer → 0, in-flight operation discarded, no response issued.

## Timing
- Reset values:
  - reqReady = 0 (during reset)
  - rspValid = 0, rspData = 0, rspErr = 0
  - aluOpCode = 0, aluIn1 = 0, aluIn2 = 0, aluShAmt = 0
- Accept at edge N → ALU inputs valid after N → result captured at N+1 → rspValid high from N+1 until the rspReady edge.
- Minimum 3 cycles per operation (IDLE, EXEC, RESP); no overlap. The earliest next accept is in the IDLE cycle following response handshake.
- ALU inputs remain held through EXEC and RESP (no toggling while idle).
- reqReady is combinational from reqValid and state; rspValid is registered.

## Configuration
- ALU_ARB_OPCHECK_EN defined:
  - In IDLE, an opcode outside the nine legal codes is still accepted.
  - EXEC is skipped and the ALU inputs are not updated.
  - RESP is entered next cycle with rspData = 0 and rspErr = 1.
  - rspErr = 0 for all legal opcodes.
- Undefined: no check, rspErr tied 0, every opcode goes to the ALU.

## Structure
- Package alu32_pkg holds:
  - localparams for the nine opcodes
  - the FSM state encoding (IDLE/EXEC/RESP)
  - the legal-opcode function used by the check
- Sub-module rr_arbiter2: 2-input round-robin grant with priority pointer, update on accept. Everything else flat in alu32_arbiter.

## Test plan
- Req0 add, in1=110, in2=10 → rspValid=2'b01, rspData=120 at 2nd edge after accept; reqReady[1] stays 0 throughout.
- Both valid in the same cycle after reset: req0 sub 110−10, req1 xor 110^10 → req0 served first (100), then req1 (100); pointer alternates on a third simultaneous pair.
- Req1 sra, in1=0x8000000C, shAmt=2 → rspData=0xE0000003; sll 0b001110 shAmt 2 → 0b111000.
- rspReady held 0 for 5 cycles → rspValid/rspData stable, reqReady=0 for new valids; release → IDLE next edge.
- ALU_ARB_OPCHECK_EN, opcode 4'b0011 → rspErr=1, rspData=0, aluIn1 unchanged; without macro → rspErr=0.
- rst_n low during EXEC → next edge: rspValid=0, ALU outputs 0, FSM IDLE, pointer 0, no response for the discarded op.
